vec_mem_sequencer: RTL
======================

// Module: vec_mem_sequencer
// PURPOSE
//  Sequences strided vector load/store commands into single-element accesses on the one-port data memory.
//  Arbitrates that memory between the vector path and the scalar load/store path, with a starvation guard.
//  Sits between the decode/issue stage and the data memory; returns gathered load data as one packed vector.
// PARAMETERS
//  NUM_ELEM     4   max elements per vector command
//  DATA_W       32  element/memory word width
//  ADDR_W       32  word address width
//  MEM_DEPTH    31  legal word addresses 0..MEM_DEPTH-1
//  MAX_SC_RUN   2   max consecutive scalar grants while a vector is in RUN
// PORTS
//  clk          in   1                 clock; all state updates on posedge
//  rst          in   1                 asynchronous, active-high reset
//  cmd_valid    in   1                 vector command offered
//  cmd_ready    out  1                 high only in IDLE
//  cmd_is_store in   1                 1=store, 0=load
//  cmd_base     in   ADDR_W            element-0 word address
//  cmd_stride   in   ADDR_W            signed word stride, two's complement
//  cmd_vl       in   $clog2(NUM_ELEM+1) vector length, 0..NUM_ELEM; larger values clamp to NUM_ELEM
//  cmd_wdata    in   NUM_ELEM*DATA_W   store data, element i at [i*DATA_W +: DATA_W]
//  sc_req       in   1                 scalar access request, held until sc_gnt
//  sc_we        in   1                 scalar write enable
//  sc_addr      in   ADDR_W            scalar word address
//  sc_wdata     in   DATA_W            scalar write data
//  sc_gnt       out  1                 scalar granted this cycle; sc_rdata valid the same cycle
//  sc_rdata     out  DATA_W            mem_rdata passed through
//  done         out  1                 one-cycle pulse when the vector command completes
//  done_rdata   out  NUM_ELEM*DATA_W   gathered load data; holds until the next done
//  done_err     out  1                 valid with done: some element address was out of range
//  mem_addr     out  ADDR_W            to data memory
//  mem_wdata    out  DATA_W
//  mem_we       out  1                 memory commits the write on the negedge of the same cycle
//  mem_re       out  1
//  mem_rdata    in   DATA_W            combinational read data, sampled at the closing posedge
// BEHAVIOUR
//  Reset: state=IDLE, elem_idx=0, sc_run=0, done=0, done_err=0, done_rdata=0; mem_we=0, mem_re=0, sc_gnt=0.
//  Reset mid-command aborts it immediately: no done pulse, and no further memory writes.
//  FSM IDLE: cmd_ready=1. On cmd_valid, latch the command and set addr_cur=cmd_base.
//   vl==0 goes to DONE; otherwise go to RUN.
//  FSM RUN: each cycle, the arbiter picks one owner of the memory port.
//   The scalar path wins if sc_req=1 and sc_run<MAX_SC_RUN; sc_run then increments.
//   Otherwise the vector element elem_idx issues and sc_run clears to 0.
//   Vector issue: mem_addr=addr_cur; mem_we=is_store; mem_re=!is_store.
//   On a load, capture mem_rdata into slot elem_idx at the posedge.
//   After issue, addr_cur+=stride (modulo 2^ADDR_W) and elem_idx++. After element vl-1, go to DONE.
//  FSM DONE: done=1 for exactly one cycle; done_err=sticky error flag; slots >= vl read 0.
//   Return to IDLE. cmd_ready is 0 during DONE.
//  IDLE or DONE: the scalar path is granted the same cycle it requests, with no starvation limit.
//  Out of range (addr_cur >= MEM_DEPTH, unsigned): suppress mem_we/mem_re, load slot=0, set sticky err.
//   The element still consumes its cycle.
//  Scalar out of range: sc_gnt=1, no memory access, sc_rdata=0.
//  Latency: handshake in cycle N, no contention -> element i issues in cycle N+1+i, done in cycle N+1+vl.
//  When no owner is selected: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
// STRUCTURE
//  Package vpu_pkg: state enum {IDLE, RUN, DONE}, DATA_W/ADDR_W defaults, MEM_DEPTH.
//  One sub-module: vms_arbiter (2-way fixed priority with sc_run starvation counter, grant + mux).
//  The FSM, address generator and gather buffer stay in the top module.
// TESTING
//  1. Reset; memory holds mem[i]=i. Load base=2, stride=3, vl=4.
//     -> done at N+5; done_rdata = {11,8,5,2}; done_err=0.
//  2. Store base=10, stride=1, vl=3, data {C,B,A}.
//     -> mem[10..12]=A,B,C; mem[13] unchanged; done at N+4.
//  3. Load with sc_req held high throughout.
//     -> grant pattern S,S,V,S,S,V...; every scalar access completes; vector completes.
//  4. Load base=29, stride=1, vl=4.
//     -> slots {0,0,30,29}; done_err=1; no memory access for addresses 31 and 32.
//  5. vl=0 -> done at N+1, done_rdata=0, no memory access.
//     Negative stride (-2) from base=8, vl=3 -> {4,6,8}.
//  6. Assert rst during RUN of a store after element 1.
//     -> elements 2 and up are never written; done stays 0; cmd_ready=1 after rst drops.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared types and default sizes for the vector memory sequencer.
package vpu_pkg;

    localparam int NUM_ELEM_DEF   = 4;
    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int MEM_DEPTH_DEF  = 31;
    localparam int MAX_SC_RUN_DEF = 2;

    // Command sequencing phases: accept, walk elements, report completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vms_arbiter.sv
// Memory-port arbiter between the scalar path and the vector element stream.
// Scalar has fixed priority, but during RUN it may win at most MAX_SC_RUN
// consecutive cycles before the vector element is forced through.
module vms_arbiter
    import vpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int MAX_SC_RUN = MAX_SC_RUN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sc_req,
    input  logic              sc_we,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic [DATA_W-1:0] sc_wdata,
    input  logic [ADDR_W-1:0] vec_addr,
    input  logic              vec_we,
    input  logic [DATA_W-1:0] vec_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sc_gnt,
    output logic              vec_gnt,
    output logic              vec_in_range,
    output logic [DATA_W-1:0] sc_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re
);

    localparam int SC_RUN_W = $clog2(MAX_SC_RUN + 1);

    logic [SC_RUN_W-1:0] sc_run_q;
    logic [SC_RUN_W-1:0] sc_run_d;
    logic                sc_in_range;

    assign sc_in_range  = (sc_addr < ADDR_W'(MEM_DEPTH));
    assign vec_in_range = (vec_addr < ADDR_W'(MEM_DEPTH));
    // Out-of-range scalar accesses are granted but read back as zero.
    assign sc_rdata     = sc_in_range ? mem_rdata : '0;

    // Grant selection, starvation counter update and memory port mux.
    always_comb begin
        sc_gnt    = 1'b0;
        vec_gnt   = 1'b0;
        sc_run_d  = sc_run_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        if (!run) begin
            // No vector work pending: scalar always wins, counter restarts.
            sc_gnt   = sc_req;
            sc_run_d = '0;
        end else if (sc_req && (sc_run_q < SC_RUN_W'(MAX_SC_RUN))) begin
            sc_gnt   = 1'b1;
            sc_run_d = sc_run_q + SC_RUN_W'(1);
        end else begin
            vec_gnt  = 1'b1;
            sc_run_d = '0;
        end

        if (sc_gnt && sc_in_range) begin
            mem_addr  = sc_addr;
            mem_we    = sc_we;
            mem_re    = !sc_we;
            mem_wdata = sc_we ? sc_wdata : '0;
        end else if (vec_gnt && vec_in_range) begin
            mem_addr  = vec_addr;
            mem_we    = vec_we;
            mem_re    = !vec_we;
            mem_wdata = vec_we ? vec_wdata : '0;
        end
    end

    // Consecutive scalar grant counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_run_q <= '0;
        end else begin
            sc_run_q <= sc_run_d;
        end
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Breaks strided vector load/store commands into single-element accesses on
// the one-port data memory, sharing it with the scalar path, and returns the
// gathered load data as one packed vector.
module vec_mem_sequencer
    import vpu_pkg::*;
#(
    parameter int NUM_ELEM   = NUM_ELEM_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int MAX_SC_RUN = MAX_SC_RUN_DEF,
    localparam int VL_W      = $clog2(NUM_ELEM + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_is_store,
    input  logic [ADDR_W-1:0]          cmd_base,
    input  logic [ADDR_W-1:0]          cmd_stride,
    input  logic [VL_W-1:0]            cmd_vl,
    input  logic [NUM_ELEM*DATA_W-1:0] cmd_wdata,
    input  logic                       sc_req,
    input  logic                       sc_we,
    input  logic [ADDR_W-1:0]          sc_addr,
    input  logic [DATA_W-1:0]          sc_wdata,
    output logic                       sc_gnt,
    output logic [DATA_W-1:0]          sc_rdata,
    output logic                       done,
    output logic [NUM_ELEM*DATA_W-1:0] done_rdata,
    output logic                       done_err,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    state_e                             state_q, state_d;
    logic                               is_store_q, is_store_d;
    logic [ADDR_W-1:0]                  stride_q, stride_d;
    logic [VL_W-1:0]                    vl_q, vl_d;
    logic [NUM_ELEM-1:0][DATA_W-1:0]    wdata_q, wdata_d;
    logic [ADDR_W-1:0]                  addr_cur_q, addr_cur_d;
    logic [VL_W-1:0]                    elem_idx_q, elem_idx_d;
    logic                               err_q, err_d;
    logic [NUM_ELEM-1:0][DATA_W-1:0]    gather_q, gather_d;
    logic [NUM_ELEM-1:0][DATA_W-1:0]    done_rdata_q, done_rdata_d;

    logic [VL_W-1:0]  vl_clamp;
    logic [IDX_W-1:0] elem_sel;
    logic             vec_gnt;
    logic             vec_in_range;

    assign vl_clamp   = (cmd_vl > VL_W'(NUM_ELEM)) ? VL_W'(NUM_ELEM) : cmd_vl;
    assign elem_sel   = elem_idx_q[IDX_W-1:0];
    assign cmd_ready  = (state_q == IDLE);
    assign done       = (state_q == DONE);
    assign done_err   = (state_q == DONE) && err_q;
    assign done_rdata = done_rdata_q;

    vms_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .MEM_DEPTH  (MEM_DEPTH),
        .MAX_SC_RUN (MAX_SC_RUN)
    ) u_arbiter (
        .clk          (clk),
        .rst          (rst),
        .run          (state_q == RUN),
        .sc_req       (sc_req),
        .sc_we        (sc_we),
        .sc_addr      (sc_addr),
        .sc_wdata     (sc_wdata),
        .vec_addr     (addr_cur_q),
        .vec_we       (is_store_q),
        .vec_wdata    (wdata_q[elem_sel]),
        .mem_rdata    (mem_rdata),
        .sc_gnt       (sc_gnt),
        .vec_gnt      (vec_gnt),
        .vec_in_range (vec_in_range),
        .sc_rdata     (sc_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re)
    );

    // Command FSM, strided address generation and load gather.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        stride_d     = stride_q;
        vl_d         = vl_q;
        wdata_d      = wdata_q;
        addr_cur_d   = addr_cur_q;
        elem_idx_d   = elem_idx_q;
        err_d        = err_q;
        gather_d     = gather_q;
        done_rdata_d = done_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    is_store_d = cmd_is_store;
                    stride_d   = cmd_stride;
                    vl_d       = vl_clamp;
                    wdata_d    = cmd_wdata;
                    addr_cur_d = cmd_base;
                    elem_idx_d = '0;
                    err_d      = 1'b0;
                    // Clearing up front makes slots beyond vl read as zero.
                    gather_d   = '0;
                    state_d    = (vl_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (vec_gnt) begin
                    if (!is_store_q) begin
                        gather_d[elem_sel] = vec_in_range ? mem_rdata : '0;
                    end
                    if (!vec_in_range) begin
                        err_d = 1'b1;
                    end
                    addr_cur_d = addr_cur_q + stride_q;
                    elem_idx_d = elem_idx_q + VL_W'(1);
                    if (elem_idx_q == (vl_q - VL_W'(1))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Publish the gathered vector as the done pulse begins; it then
        // holds while the next command reuses the gather buffer.
        if ((state_d == DONE) && (state_q != DONE)) begin
            done_rdata_d = gather_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            stride_q     <= '0;
            vl_q         <= '0;
            wdata_q      <= '0;
            addr_cur_q   <= '0;
            elem_idx_q   <= '0;
            err_q        <= 1'b0;
            gather_q     <= '0;
            done_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            stride_q     <= stride_d;
            vl_q         <= vl_d;
            wdata_q      <= wdata_d;
            addr_cur_q   <= addr_cur_d;
            elem_idx_q   <= elem_idx_d;
            err_q        <= err_d;
            gather_q     <= gather_d;
            done_rdata_q <= done_rdata_d;
        end
    end

endmodule
